fixed_point_accumulator: RTL

- Downstream consumer of fixed_point_multiplier in the convolution datapath.
- Sums NUM_TERMS signed fixed-point products (one 3x3 depthwise window by default) onto a per-channel bias.
- Saturates the sum back to BITSIZE and presents one result per window with a valid/ready handshake.
- Feeds the activation / output buffer stage.

---
 rtl/cnn_fixed_pkg.sv | 18 +
 rtl/fixed_point_saturate.sv | 38 +++
 rtl/fixed_point_accumulator.sv | 125 ++++++++++++
 3 files changed

// File: rtl/cnn_fixed_pkg.sv
// Shared fixed-point constants for the CNN datapath.
// Used by the multiplier, the saturator and the accumulator.
package cnn_fixed_pkg;

  localparam int BITSIZE   = 14;
  localparam int FRAC_BITS = 7;

  localparam int MAX_VAL = (1 << (BITSIZE - 1)) - 1;
  localparam int MIN_VAL = -(1 << (BITSIZE - 1));

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ACCUM = 2'd1;
  localparam state_t ST_ROUND = 2'd2;
  localparam state_t ST_OUT   = 2'd3;

endpackage

// File: rtl/fixed_point_saturate.sv
// Combinational signed clamp from ACC_BITS down to BITSIZE.
// Flags when the input was outside the representable range.
module fixed_point_saturate #(
  parameter int ACC_BITS = 24,
  parameter int BITSIZE  = 14
) (
  input  logic [ACC_BITS-1:0] acc,
  output logic [BITSIZE-1:0]  result,
  output logic                clamp
);

  localparam logic [ACC_BITS-1:0] HI =
    {{(ACC_BITS-BITSIZE+1){1'b0}},
     {(BITSIZE-1){1'b1}}};
  localparam logic [ACC_BITS-1:0] LO =
    {{(ACC_BITS-BITSIZE+1){1'b1}},
     {(BITSIZE-1){1'b0}}};

  logic above;
  logic below;

  assign above = $signed(acc) > $signed(HI);
  assign below = $signed(acc) < $signed(LO);

  // clamp to the nearest rail, else truncate
  always_comb begin
    result = acc[BITSIZE-1:0];
    clamp  = 1'b0;
    if (above) begin
      result = {1'b0, {(BITSIZE-1){1'b1}}};
      clamp  = 1'b1;
    end else if (below) begin
      result = {1'b1, {(BITSIZE-1){1'b0}}};
      clamp  = 1'b1;
    end
  end

endmodule

// File: rtl/fixed_point_accumulator.sv
// Windowed signed product accumulator with bias and saturation.
// Optional ACC_RELU_EN: negative results are forced to zero.
module fixed_point_accumulator
  import cnn_fixed_pkg::*;
#(
  parameter int BITSIZE   = cnn_fixed_pkg::BITSIZE,
  parameter int FRAC_BITS = cnn_fixed_pkg::FRAC_BITS,
  parameter int NUM_TERMS = 9,
  parameter int ACC_BITS  = 24,
  parameter int CNT_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_flag,
  input  logic [BITSIZE-1:0] mul_result,
  input  logic               mul_valid,
  input  logic [BITSIZE-1:0] bias,
  input  logic               out_ready,
  output logic [BITSIZE-1:0] acc_out,
  output logic               out_valid,
  output logic               busy,
  output logic               overflow
);

  if (NUM_TERMS < 1) begin : g_bad_terms
    $error("NUM_TERMS must be >= 1");
  end
  if ((1 << CNT_W) <= NUM_TERMS) begin : g_bad_cnt
    $error("CNT_W too small for NUM_TERMS");
  end
  if (ACC_BITS < BITSIZE + $clog2(NUM_TERMS + 1))
  begin : g_bad_acc
    $error("ACC_BITS too small");
  end
  if (FRAC_BITS >= BITSIZE) begin : g_bad_frac
    $error("FRAC_BITS must be < BITSIZE");
  end

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(NUM_TERMS - 1);

  state_t               state;
  logic [ACC_BITS-1:0]  acc;
  logic [CNT_W-1:0]     count;
  logic [ACC_BITS-1:0]  bias_ext;
  logic [ACC_BITS-1:0]  mul_ext;
  logic [BITSIZE-1:0]   sat_res;
  logic                 sat_clamp;
  logic [BITSIZE-1:0]   round_val;
  logic                 handshake;

  assign bias_ext = {{(ACC_BITS-BITSIZE){bias[BITSIZE-1]}},
                     bias};
  assign mul_ext  = {{(ACC_BITS-BITSIZE){mul_result[BITSIZE-1]}},
                     mul_result};

  assign handshake = out_valid && out_ready;
  assign busy      = (state != ST_IDLE);

  fixed_point_saturate #(
    .ACC_BITS (ACC_BITS),
    .BITSIZE  (BITSIZE)
  ) u_sat (
    .acc    (acc),
    .result (sat_res),
    .clamp  (sat_clamp)
  );

`ifdef ACC_RELU_EN
  assign round_val = sat_res[BITSIZE-1] ? '0 : sat_res;
`else
  assign round_val = sat_res;
`endif

  // window sequencing, accumulation and result register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      acc       <= '0;
      count     <= '0;
      acc_out   <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == ST_IDLE): begin
          if (start_flag) begin
            acc   <= bias_ext;
            count <= '0;
            state <= ST_ACCUM;
          end
        end
        (state == ST_ACCUM): begin
          if (mul_valid) begin
            acc   <= acc + mul_ext;
            count <= count + 1'b1;
            if (count == LAST) begin
              state <= ST_ROUND;
            end
          end
        end
        (state == ST_ROUND): begin
          acc_out   <= round_val;
          overflow  <= overflow | sat_clamp;
          out_valid <= 1'b1;
          state     <= ST_OUT;
        end
        (state == ST_OUT): begin
          if (handshake) begin
            out_valid <= 1'b0;
            if (start_flag) begin
              acc   <= bias_ext;
              count <= '0;
              state <= ST_ACCUM;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
